hx8352_init_sequencer: RTL and testbench
========================================

# hx8352_init_sequencer

Upstream driver for `hx8352_bus_controller`.
- After reset it pulses the panel hardware reset line.
- It then replays a fixed register-init table, with delays, as command/data transfers.
- Next it programs the full-screen GRAM window and issues GRAM write (0x22).
- It then streams pixels from a valid/ready source into the bus controller, one 16-bit transfer per pixel, re-arming the window every frame.

## Interface
Parameters:
- `WIDTH`, 240, columns per frame
- `HEIGHT`, 400, rows per frame
- `DELAY_UNIT_CYCLES`, 50000, clk cycles per delay unit (1 ms at 50 MHz)
- `RESET_LOW_UNITS`, 10, units `lcd_rst_n` is held low
- `RESET_WAIT_UNITS`, 120, units waited after `lcd_rst_n` rises

Ports:
- `clk` in 1: single clock
- `rst` in 1: asynchronous, active-high reset
- `bus_busy` in 1: busy from the bus controller
- `bus_data` out 16: transfer word
- `bus_data_command` out 1: 0 = register index, 1 = data/pixel
- `bus_transfer_step` out 1: one-cycle start pulse
- `lcd_rst_n` out 1: panel hardware reset
- `pixel_data` in 16: RGB565 pixel
- `pixel_valid` in 1: source has a pixel
- `pixel_ready` out 1: pixel accepted when valid and ready are both high
- `init_done` out 1: sticky high once the first GRAM write command completes
- `frame_done` out 1: one-cycle pulse after the last pixel transfer of a frame

## Operation
- **Reset values:** every output 0; FSM in `RST_LOW`.
- **Init table:** internal ROM with 6-bit index; each entry is {op[1:0], val[15:0]}.
  - op 00 CMD: transfer `val` with command=0.
  - op 01 DATA: transfer `val` with command=1.
  - op 10 DELAY: wait `val`×`DELAY_UNIT_CYCLES` cycles; `val`=0 means a one-cycle pass-through.
  - op 11 END: leave the init phase.
  - Table begins CMD 0x0083, DATA 0x0002, CMD 0x0085, DATA 0x0003, DELAY 0x000A and ends with END.
  - Index 63 without an END entry is treated as END.
- **States:**
  - `RST_LOW`: `lcd_rst_n`=0 for `RESET_LOW_UNITS` units.
  - `RST_WAIT`: `lcd_rst_n`=1 for `RESET_WAIT_UNITS` units.
  - `FETCH`: decode the current entry.
  - `ISSUE` → `WAIT_ACK` → `WAIT_IDLE`: transfer subroutine, returns to the caller phase.
  - `DELAY`: run the delay counter.
  - `WIN`: emit the 17-transfer window sequence.
  - `PIX`: accept and transfer pixels.
- **Transfer subroutine:**
  - `ISSUE` drives `bus_transfer_step`=1 for exactly one cycle.
  - `WAIT_ACK` holds until `bus_busy`=1; `WAIT_IDLE` holds until `bus_busy`=0.
  - `bus_data` and `bus_data_command` stay stable from `ISSUE` through `WAIT_IDLE`.
- **Window sequence** (CMD/DATA pairs), values derived from `WIDTH`-1 and `HEIGHT`-1:
  - 0x02 = 0x0000, 0x03 = 0x0000 (column start)
  - 0x04 = 0x0000, 0x05 = 0x00EF (column end)
  - 0x06 = 0x0000, 0x07 = 0x0000 (row start)
  - 0x08 = 0x0001, 0x09 = 0x008F (row end)
  - then CMD 0x0022.
- **PIX state:**
  - `pixel_ready`=1 only in `PIX`, with no transfer in flight.
  - On accept, the pixel is latched into `bus_data` with command=1.
  - A pixel counter counts 0..`WIDTH`×`HEIGHT`-1.
  - After the last pixel completes: `frame_done` pulses, counter resets to 0, `WIN` is re-entered, and the next frame starts.
- **`pixel_valid` rules:**
  - `pixel_valid` outside `PIX` is ignored; nothing is consumed.
  - `pixel_valid` low in `PIX` keeps the FSM waiting indefinitely.
- **Counters:**
  - Delay unit counter is `$clog2(DELAY_UNIT_CYCLES)` bits; units counter is 16 bits.
  - Pixel counter is wide enough for `WIDTH`×`HEIGHT`.
- **Reset mid-operation:** everything aborts to reset values. The panel is re-initialised from index 0.
- **Busy after reset:** the bus controller's busy-after-reset is absorbed by `RST_LOW`.

## Timing
- Pixel accepted at cycle t:
  - `bus_transfer_step`=1 at t+1.
  - `bus_busy` seen high at t+2, low at t+5.
  - `pixel_ready` high again at t+6 at the earliest, i.e. 6 cycles per pixel.
- Each CMD/DATA init entry costs 6 cycles: `FETCH` + `ISSUE` + 4 handshake cycles.
- `init_done` rises the cycle after the 0x22 transfer's `WAIT_IDLE` sees `bus_busy`=0.
- `frame_done` is asserted in the same cycle the FSM leaves the last pixel's `WAIT_IDLE`.

## Configuration
- `HX8352_SEQ_TEST_PATTERN_EN`
  - Defined:
    - Pixels come from an internal generator of 8 vertical bars, `WIDTH`/8 columns each.
    - Bar colours in order: 0xFFFF, 0xFFE0, 0x07FF, 0x07E0, 0xF81F, 0xF800, 0x001F, 0x0000.
    - `pixel_ready` is held 0 and `pixel_data`/`pixel_valid` are ignored.
    - The column counter wraps every `WIDTH` pixels.
  - Undefined: external stream only; generator logic absent.

## Test plan
- **Reset sequence** (`DELAY_UNIT_CYCLES`=4, bench bus model mimicking the controller's 3-cycle busy): release `rst` → `lcd_rst_n`=0 for 40 cycles, then 1; first transfer begins 480 cycles later; first two transfers are 0x0083/cmd0 and 0x0002/cmd1.
- **DELAY entry** 0x000A → exactly 40 idle cycles between the preceding transfer's completion and the next `ISSUE`.
- **Window programming:** after END → 17 transfers in the listed order, ending with 0x0022/cmd0; `init_done` then rises; `pixel_ready`=1 the following cycle.
- **Pixel stream** (`WIDTH`=8, `HEIGHT`=2, `pixel_valid` held 1, data 0x1234 incrementing) → 16 data transfers at 6-cycle spacing; `frame_done` pulses once; window sequence repeats before pixel 17.
- **Reset mid-transfer:** assert `rst` during `WAIT_IDLE` → all outputs 0 immediately; after release the sequence restarts at 0x0083.
- **Test pattern** (macro defined, `WIDTH`=16): pixel words follow 0xFFFF, 0xFFFF, 0xFFE0, 0xFFE0 … 0x0000, 0x0000, then repeat; `pixel_ready` stays 0.

Source files
------------

// File: rtl/hx8352_init_sequencer.sv
// HX8352 power-up sequencer: panel reset, register init table, GRAM window, pixel stream.
// Define HX8352_SEQ_TEST_PATTERN_EN to replace the pixel input with an 8-bar colour generator.
module hx8352_init_sequencer #(
   parameter int WIDTH             = 240,
   parameter int HEIGHT            = 400,
   parameter int DELAY_UNIT_CYCLES = 50000,
   parameter int RESET_LOW_UNITS   = 10,
   parameter int RESET_WAIT_UNITS  = 120
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        bus_busy,
   output logic [15:0] bus_data,
   output logic        bus_data_command,
   output logic        bus_transfer_step,
   output logic        lcd_rst_n,
   input  logic [15:0] pixel_data,
   input  logic        pixel_valid,
   output logic        pixel_ready,
   output logic        init_done,
   output logic        frame_done
);

   localparam int UCW  = (DELAY_UNIT_CYCLES > 1) ? $clog2(DELAY_UNIT_CYCLES) : 1;
   localparam int NPIX = WIDTH * HEIGHT;
   localparam int PCW  = (NPIX > 1) ? $clog2(NPIX) : 1;
   localparam logic [15:0] COL_END = 16'(WIDTH - 1);
   localparam logic [15:0] ROW_END = 16'(HEIGHT - 1);

   localparam logic [3:0] RST_LOW   = 4'd0;
   localparam logic [3:0] RST_WAIT  = 4'd1;
   localparam logic [3:0] FETCH     = 4'd2;
   localparam logic [3:0] ISSUE     = 4'd3;
   localparam logic [3:0] WAIT_ACK  = 4'd4;
   localparam logic [3:0] WAIT_IDLE = 4'd5;
   localparam logic [3:0] DELAY     = 4'd6;
   localparam logic [3:0] WIN       = 4'd7;
   localparam logic [3:0] PIX       = 4'd8;

   localparam logic [1:0] PH_INIT = 2'd0;
   localparam logic [1:0] PH_WIN  = 2'd1;
   localparam logic [1:0] PH_PIX  = 2'd2;

   localparam logic [1:0] OP_CMD = 2'b00;
   localparam logic [1:0] OP_DAT = 2'b01;
   localparam logic [1:0] OP_DLY = 2'b10;
   localparam logic [1:0] OP_END = 2'b11;

   function automatic logic [17:0] init_rom(input logic [5:0] i);
      case (i)
         6'd0:    init_rom = {OP_CMD, 16'h0083};
         6'd1:    init_rom = {OP_DAT, 16'h0002};
         6'd2:    init_rom = {OP_CMD, 16'h0085};
         6'd3:    init_rom = {OP_DAT, 16'h0003};
         6'd4:    init_rom = {OP_DLY, 16'h000A};
         6'd5:    init_rom = {OP_CMD, 16'h008B};
         6'd6:    init_rom = {OP_DAT, 16'h0093};
         6'd7:    init_rom = {OP_CMD, 16'h008C};
         6'd8:    init_rom = {OP_DAT, 16'h0091};
         6'd9:    init_rom = {OP_CMD, 16'h0091};
         6'd10:   init_rom = {OP_DAT, 16'h0001};
         6'd11:   init_rom = {OP_CMD, 16'h0018};
         6'd12:   init_rom = {OP_DAT, 16'h0088};
         6'd13:   init_rom = {OP_CMD, 16'h0019};
         6'd14:   init_rom = {OP_DAT, 16'h0001};
         6'd15:   init_rom = {OP_DLY, 16'h0005};
         6'd16:   init_rom = {OP_CMD, 16'h0001};
         6'd17:   init_rom = {OP_DAT, 16'h0000};
         6'd18:   init_rom = {OP_CMD, 16'h001F};
         6'd19:   init_rom = {OP_DAT, 16'h0088};
         6'd20:   init_rom = {OP_DLY, 16'h0005};
         6'd21:   init_rom = {OP_CMD, 16'h0028};
         6'd22:   init_rom = {OP_DAT, 16'h0038};
         6'd23:   init_rom = {OP_DLY, 16'h0028};
         6'd24:   init_rom = {OP_CMD, 16'h0028};
         6'd25:   init_rom = {OP_DAT, 16'h003C};
         6'd26:   init_rom = {OP_CMD, 16'h0016};
         6'd27:   init_rom = {OP_DAT, 16'h0008};
         default: init_rom = {OP_END, 16'h0000};
      endcase
   endfunction

   // Entries 0..15 are CMD/DATA pairs for regs 0x02..0x09, entry 16 is GRAM write.
   function automatic logic [16:0] win_word(input logic [4:0] i);
      logic [15:0] v;
      v = 16'h0000;
      case (i[3:1])
         3'd2:    v = {8'h00, COL_END[15:8]};
         3'd3:    v = {8'h00, COL_END[7:0]};
         3'd6:    v = {8'h00, ROW_END[15:8]};
         3'd7:    v = {8'h00, ROW_END[7:0]};
         default: v = 16'h0000;
      endcase
      if (i[4])
         win_word = {1'b0, 16'h0022};
      else if (!i[0])
         win_word = {1'b0, 8'h00, {5'd0, i[3:1]} + 8'd2};
      else
         win_word = {1'b1, v};
   endfunction

   logic [3:0]     state;
   logic [1:0]     ret_ph;
   logic [5:0]     idx;
   logic [4:0]     win_idx;
   logic [UCW-1:0] unit_cnt;
   logic [15:0]    units_left;
   logic [PCW-1:0] pix_cnt;
   logic [1:0]     rom_op;
   logic [15:0]    rom_val;
   logic           tick;
   logic           src_valid;
   logic [15:0]    src_data;

   always_comb begin
      {rom_op, rom_val} = init_rom(idx);
   end

   assign tick              = (unit_cnt == UCW'(DELAY_UNIT_CYCLES - 1));
   assign bus_transfer_step = (state == ISSUE);
   assign frame_done        = (state == WAIT_IDLE) && !bus_busy &&
                              (ret_ph == PH_PIX) && (pix_cnt == PCW'(NPIX - 1));

`ifdef HX8352_SEQ_TEST_PATTERN_EN
   localparam int CW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam int BAR_W = (WIDTH / 8 > 0) ? WIDTH / 8 : 1;

   logic [CW-1:0] col_cnt;
   logic [CW-1:0] bar_cnt;
   logic [2:0]    bar_idx;
   logic          unused_pix;

   assign unused_pix  = ^{pixel_data, pixel_valid};
   assign pixel_ready = 1'b0;
   assign src_valid   = 1'b1;

   always_comb begin
      case (bar_idx)
         3'd0:    src_data = 16'hFFFF;
         3'd1:    src_data = 16'hFFE0;
         3'd2:    src_data = 16'h07FF;
         3'd3:    src_data = 16'h07E0;
         3'd4:    src_data = 16'hF81F;
         3'd5:    src_data = 16'hF800;
         3'd6:    src_data = 16'h001F;
         default: src_data = 16'h0000;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         col_cnt <= '0;
         bar_cnt <= '0;
         bar_idx <= 3'd0;
      end else if (state == PIX) begin
         if (col_cnt == CW'(WIDTH - 1)) begin
            col_cnt <= '0;
            bar_cnt <= '0;
            bar_idx <= 3'd0;
         end else begin
            col_cnt <= col_cnt + 1'b1;
            if (bar_cnt == CW'(BAR_W - 1) && bar_idx != 3'd7) begin
               bar_cnt <= '0;
               bar_idx <= bar_idx + 3'd1;
            end else begin
               bar_cnt <= bar_cnt + 1'b1;
            end
         end
      end
   end
`else
   assign pixel_ready = (state == PIX);
   assign src_valid   = pixel_valid;
   assign src_data    = pixel_data;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state            <= RST_LOW;
         ret_ph           <= PH_INIT;
         idx              <= 6'd0;
         win_idx          <= 5'd0;
         unit_cnt         <= '0;
         units_left       <= 16'(RESET_LOW_UNITS);
         pix_cnt          <= '0;
         bus_data         <= 16'h0000;
         bus_data_command <= 1'b0;
         lcd_rst_n        <= 1'b0;
         init_done        <= 1'b0;
      end else begin
         case (state)
            RST_LOW, RST_WAIT, DELAY: begin
               if (tick) begin
                  unit_cnt <= '0;
                  if (units_left > 16'd1) begin
                     units_left <= units_left - 16'd1;
                  end else if (state == RST_LOW) begin
                     state      <= RST_WAIT;
                     lcd_rst_n  <= 1'b1;
                     units_left <= 16'(RESET_WAIT_UNITS);
                  end else begin
                     state <= FETCH;
                  end
               end else begin
                  unit_cnt <= unit_cnt + 1'b1;
               end
            end
            FETCH: begin
               if (idx == 6'd63 || rom_op == OP_END) begin
                  state <= WIN;
               end else begin
                  idx <= idx + 6'd1;
                  if (rom_op == OP_DLY) begin
                     // A zero delay falls straight through to the next entry.
                     if (rom_val != 16'h0000) begin
                        units_left <= rom_val;
                        unit_cnt   <= '0;
                        state      <= DELAY;
                     end
                  end else begin
                     bus_data         <= rom_val;
                     bus_data_command <= rom_op[0];
                     ret_ph           <= PH_INIT;
                     state            <= ISSUE;
                  end
               end
            end
            WIN: begin
               {bus_data_command, bus_data} <= win_word(win_idx);
               ret_ph <= PH_WIN;
               state  <= ISSUE;
            end
            ISSUE: state <= WAIT_ACK;
            WAIT_ACK: begin
               if (bus_busy) state <= WAIT_IDLE;
            end
            WAIT_IDLE: begin
               if (!bus_busy) begin
                  case (ret_ph)
                     PH_WIN: begin
                        if (win_idx == 5'd16) begin
                           win_idx   <= 5'd0;
                           init_done <= 1'b1;
                           state     <= PIX;
                        end else begin
                           win_idx <= win_idx + 5'd1;
                           state   <= WIN;
                        end
                     end
                     PH_PIX: begin
                        if (pix_cnt == PCW'(NPIX - 1)) begin
                           pix_cnt <= '0;
                           state   <= WIN;
                        end else begin
                           pix_cnt <= pix_cnt + 1'b1;
                           state   <= PIX;
                        end
                     end
                     default: state <= FETCH;
                  endcase
               end
            end
            PIX: begin
               if (src_valid) begin
                  bus_data         <= src_data;
                  bus_data_command <= 1'b1;
                  ret_ph           <= PH_PIX;
                  state            <= ISSUE;
               end
            end
            default: state <= RST_LOW;
         endcase
      end
   end

endmodule

// File: tb/tb_hx8352_init_sequencer.sv
// Bench for hx8352_init_sequencer with a 3-cycle-busy bus model and a pixel scoreboard.
// Also exercises the HX8352_SEQ_TEST_PATTERN_EN build when that macro is defined.
module tb_hx8352_init_sequencer;

`ifdef HX8352_SEQ_TEST_PATTERN_EN
   localparam int W = 16;
   localparam logic RDY_EXP = 1'b0;
`else
   localparam int W = 8;
   localparam logic RDY_EXP = 1'b1;
`endif
   localparam int H   = 2;
   localparam int U   = 4;
   localparam int RLU = 10;
   localparam int RWU = 120;

   logic        clk = 1'b0;
   logic        rst;
   logic        bus_busy;
   logic [15:0] bus_data;
   logic        bus_data_command;
   logic        bus_transfer_step;
   logic        lcd_rst_n;
   logic [15:0] pixel_data;
   logic        pixel_valid;
   logic        pixel_ready;
   logic        init_done;
   logic        frame_done;

   hx8352_init_sequencer #(
      .WIDTH(W), .HEIGHT(H), .DELAY_UNIT_CYCLES(U),
      .RESET_LOW_UNITS(RLU), .RESET_WAIT_UNITS(RWU)
   ) dut (
      .clk(clk), .rst(rst), .bus_busy(bus_busy),
      .bus_data(bus_data), .bus_data_command(bus_data_command),
      .bus_transfer_step(bus_transfer_step), .lcd_rst_n(lcd_rst_n),
      .pixel_data(pixel_data), .pixel_valid(pixel_valid),
      .pixel_ready(pixel_ready), .init_done(init_done),
      .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   // Bus controller stand-in: busy for 3 cycles after each start pulse.
   logic [1:0] bcnt;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) bcnt <= 2'd0;
      else if (bus_transfer_step) bcnt <= 2'd3;
      else if (bcnt != 2'd0) bcnt <= bcnt - 2'd1;
   end
   assign bus_busy = (bcnt != 2'd0);

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   logic [15:0] tr_d[$];
   logic        tr_c[$];
   int          tr_t[$];
   int          fd_t[$];
   int          fd_cnt = 0;
   int          unstable = 0;
   int          early_ready = 0;
   int          ready_hi = 0;
   logic [16:0] hold_w = '0;

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   initial forever begin
      @(negedge clk);
      if (!rst) begin
         if (bus_transfer_step) begin
            tr_d.push_back(bus_data);
            tr_c.push_back(bus_data_command);
            tr_t.push_back(cyc);
            hold_w = {bus_data_command, bus_data};
         end else if (bus_busy && {bus_data_command, bus_data} !== hold_w) begin
            unstable++;
         end
         if (frame_done) begin
            fd_cnt++;
            fd_t.push_back(cyc);
         end
         if (pixel_ready && !init_done) early_ready++;
         if (pixel_ready) ready_hi++;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [16:0] trw(input int i);
      if (i >= 0 && i < tr_d.size()) return {tr_c[i], tr_d[i]};
      return 'x;
   endfunction

   function automatic int trt(input int i);
      if (i >= 0 && i < tr_t.size()) return tr_t[i];
      return -100000;
   endfunction

   function automatic logic [31:0] outs();
      return 32'({bus_data, bus_data_command, bus_transfer_step,
                  lcd_rst_n, pixel_ready, init_done, frame_done});
   endfunction

   // Window sequence derived from the frame geometry.
   function automatic logic [16:0] win_exp(input int j);
      int v[8];
      v[0] = 0; v[1] = 0;
      v[2] = (W - 1) / 256; v[3] = (W - 1) % 256;
      v[4] = 0; v[5] = 0;
      v[6] = (H - 1) / 256; v[7] = (H - 1) % 256;
      if (j == 16) return {1'b0, 16'h0022};
      if (j % 2 == 0) return {1'b0, 16'(2 + j / 2)};
      return {1'b1, 16'(v[j / 2])};
   endfunction

   int t0, t1, t2, n, ni, base, m, acc;
   logic [15:0] pixq[$];
   logic [16:0] e;

   initial begin
      rst = 1'b1;
      pixel_valid = 1'b0;
      pixel_data = 16'h0000;
      repeat (3) @(negedge clk);
      chk("reset_outputs", outs(), 32'd0);

      rst = 1'b0;
      t0 = cyc;
      n = 0;
      while (!lcd_rst_n && n < 1000) begin
         @(posedge clk); #1; n++;
      end
      chk("rst_low_cycles", 32'(cyc - t0), 32'(RLU * U));
      t1 = cyc;
      n = 0;
      while (tr_d.size() == 0 && n < 2000) begin
         @(negedge clk); n++;
      end
      // Wait units elapse, then one table fetch before the first start pulse.
      chk("rst_wait_to_first_step", 32'(trt(0) - t1), 32'(RWU * U + 1));

      n = 0;
      while (!init_done && n < 20000) begin
         @(negedge clk); n++;
      end
      t2 = cyc;
      chk("init_done_seen", 32'(init_done), 32'd1);
      chk("ready_with_init_done", 32'(pixel_ready), 32'(RDY_EXP));
      ni = tr_d.size();
      chk("init_done_latency", 32'(t2 - trt(ni - 1)), 32'd5);
      chk("init_word0", 32'(trw(0)), 32'({1'b0, 16'h0083}));
      chk("init_word1", 32'(trw(1)), 32'({1'b1, 16'h0002}));
      chk("init_word2", 32'(trw(2)), 32'({1'b0, 16'h0085}));
      chk("init_word3", 32'(trw(3)), 32'({1'b1, 16'h0003}));
      chk("init_pair_spacing", 32'(trt(3) - trt(2)), 32'd6);
      // Normal 6-cycle entry, plus the delay entry's fetch and its 40 wait cycles.
      chk("delay_gap", 32'(trt(4) - trt(3)), 32'(6 + 1 + 10 * U));
      for (int j = 0; j < 17; j++)
         chk($sformatf("window_%0d", j), 32'(trw(ni - 17 + j)), 32'(win_exp(j)));
      chk("no_ready_before_init", 32'(early_ready), 32'd0);
      base = ni;

`ifndef HX8352_SEQ_TEST_PATTERN_EN
      acc = 0;
      n = 0;
      while (acc < 2 * W * H && n < 5000) begin
         if (acc < W * H) begin
            pixel_valid = 1'b1;
            pixel_data = 16'h1234 + 16'(acc);
         end else begin
            pixel_valid = 1'($urandom_range(0, 1));
            pixel_data = 16'($urandom);
         end
         if (pixel_ready && pixel_valid) begin
            pixq.push_back(pixel_data);
            acc++;
         end
         @(negedge clk);
         n++;
      end
      pixel_valid = 1'b0;
      n = 0;
      while (fd_cnt < 2 && n < 200) begin
         @(negedge clk); n++;
      end
      chk("frame_done_count", 32'(fd_cnt), 32'd2);
      chk("first_pixel_latency", 32'(trt(base) - t2), 32'd1);
      m = 0;
      for (int i = 1; i < W * H; i++)
         if (trt(base + i) - trt(base + i - 1) != 6) m++;
      chk("pixel_spacing_bad", 32'(m), 32'd0);
      chk("frame_done_timing", 32'(fd_t[0] - trt(base + W * H - 1)), 32'd4);
      for (int j = 0; j < 2 * W * H + 17; j++) begin
         if (j < W * H) e = {1'b1, pixq[j]};
         else if (j < W * H + 17) e = win_exp(j - W * H);
         else e = {1'b1, pixq[j - 17]};
         chk($sformatf("stream_%0d", j), 32'(trw(base + j)), 32'(e));
      end
`else
      n = 0;
      while (fd_cnt < 1 && n < 2000) begin
         pixel_valid = 1'($urandom_range(0, 1));
         pixel_data = 16'($urandom);
         @(negedge clk);
         n++;
      end
      pixel_valid = 1'b0;
      chk("pattern_frame_done", 32'(fd_cnt), 32'd1);
      chk("pattern_ready_low", 32'(ready_hi), 32'd0);
      for (int i = 0; i < W * H; i++) begin
         case ((i % W) / (W / 8))
            0: e = {1'b1, 16'hFFFF};
            1: e = {1'b1, 16'hFFE0};
            2: e = {1'b1, 16'h07FF};
            3: e = {1'b1, 16'h07E0};
            4: e = {1'b1, 16'hF81F};
            5: e = {1'b1, 16'hF800};
            6: e = {1'b1, 16'h001F};
            default: e = {1'b1, 16'h0000};
         endcase
         chk($sformatf("pattern_%0d", i), 32'(trw(base + i)), 32'(e));
      end
`endif
      chk("data_stable_in_transfer", 32'(unstable), 32'd0);

      m = tr_d.size();
      n = 0;
      while (tr_d.size() == m && n < 200) begin
         @(negedge clk); n++;
      end
      chk("transfer_before_abort", 32'(tr_d.size() > m), 32'd1);
      @(posedge clk);
      @(posedge clk);
      #2 rst = 1'b1;
      #1 chk("abort_outputs", outs(), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      m = tr_d.size();
      n = 0;
      while (tr_d.size() == m && n < 3000) begin
         @(negedge clk); n++;
      end
      chk("restart_word", 32'(trw(m)), 32'({1'b0, 16'h0083}));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
